// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - funct3 access-size codes (F3_*)
//   - responder FSM state encoding
//   - MAX_WAIT: largest supported number of wait states
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;  // byte, sign-extended
  localparam logic [2:0] F3_H  = 3'b001;  // half, sign-extended
  localparam logic [2:0] F3_W  = 3'b010;  // word
  localparam logic [2:0] F3_BU = 3'b100;  // byte, zero-extended
  localparam logic [2:0] F3_HU = 3'b101;  // half, zero-extended

  localparam int MAX_WAIT = 15;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: 2^DEPTH_W x 32 synchronous RAM, one byte lane per column.
//   clk   : rising-edge clock
//   en    : access enable (read and/or write this cycle)
//   we    : per-byte write enables, qualified by en
//   addr  : word index
//   wdata : write data, already steered onto the correct lanes
//   rdata : registered read data (old contents when read and write collide)
// Contents are never reset.
module dmem_array #(
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               en,
  input  logic [3:0]         we,
  input  logic [DEPTH_W-1:0] addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata
);

  localparam int DEPTH = 1 << DEPTH_W;

  // Each byte lane is its own RAM so the byte enables map straight onto
  // independent write ports.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [0:DEPTH-1];
      logic [7:0] rd_byte_reg;

      always_ff @(posedge clk) begin
        if (en) begin
          if (we[gi]) begin
            lane_mem[addr] <= wdata[gi*8 +: 8];
          end
          rd_byte_reg <= lane_mem[addr];
        end
      end

      assign rdata[gi*8 +: 8] = rd_byte_reg;
    end
  endgenerate

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: load/store responder behind the core's memory interface.
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   req_valid  : request present; accepted while req_ready=1
//   req_ready  : high only when idle
//   MemWrite   : 1 = store (wins over ResultSrc)
//   ResultSrc  : 1 = load (when MemWrite=0)
//   funct3     : access size / sign
//   ALUResult  : byte address, or pass-through value for non-memory requests
//   WD         : store data
//   resp_valid : one-cycle response strobe
//   Result     : write-back value, held between responses
//   err        : misaligned / unsupported access, valid with resp_valid
// Flow: IDLE -> [WAIT x WAIT_CYCLES] -> ACCESS -> RESP -> IDLE. The array is
// read/written on the edge leaving ACCESS; RESP formats the registered read
// data, and the registered response appears on the edge leaving RESP, so the
// responder is already back in IDLE while resp_valid is high.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_W     = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        MemWrite,
  input  logic        ResultSrc,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WD,
  output logic        resp_valid,
  output logic [31:0] Result,
  output logic        err
);

  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state_reg, state_next;
  logic [3:0]  wait_cnt_reg, wait_cnt_next;
  logic        mem_write_reg, result_src_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] alu_result_reg, wd_reg;
  logic [31:0] result_reg, result_next;
  logic        err_reg, err_next;
  logic        resp_valid_reg, resp_valid_next;

  logic        accept;
  logic        is_store, is_load, size_ok, misaligned, access_err;
  logic [1:0]  lane;
  logic [3:0]  lane_we;
  logic [31:0] store_data, rd_data, load_data;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic        arr_en;
  logic [3:0]  arr_we;

  assign accept = (state_reg == IDLE) && req_valid;

  // Decode of the latched request; stable from acceptance through RESP.
  always_comb begin
    lane       = alu_result_reg[1:0];
    is_store   = mem_write_reg;
    is_load    = !mem_write_reg && result_src_reg;
    size_ok    = 1'b0;
    misaligned = 1'b0;
    lane_we    = 4'b1111;
    store_data = wd_reg;
    unique case (funct3_reg)
      F3_B, F3_H, F3_W: size_ok = 1'b1;
      F3_BU, F3_HU:     size_ok = !is_store;
      default:          size_ok = 1'b0;
    endcase
    if (funct3_reg[1:0] == 2'b01) begin
      misaligned = lane[0];
    end else if (funct3_reg[1:0] == 2'b10) begin
      misaligned = (lane != 2'b00);
    end
    access_err = (is_store || is_load) && (!size_ok || misaligned);
    // Replicate the store data so every candidate lane sees it; the byte
    // enables pick the lanes that actually change.
    case (funct3_reg[1:0])
      2'b00: begin
        lane_we    = 4'b0001 << lane;
        store_data = {4{wd_reg[7:0]}};
      end
      2'b01: begin
        lane_we    = lane[1] ? 4'b1100 : 4'b0011;
        store_data = {2{wd_reg[15:0]}};
      end
      default: begin
        lane_we    = 4'b1111;
        store_data = wd_reg;
      end
    endcase
  end

  // Faulting and non-memory requests never touch the array.
  assign arr_en = (state_reg == ACCESS) && (is_store || is_load) && !access_err;
  assign arr_we = is_store ? lane_we : 4'b0000;

  dmem_array #(
    .DEPTH_W(DEPTH_W)
  ) u_array (
    .clk  (clk),
    .en   (arr_en),
    .we   (arr_we),
    .addr (alu_result_reg[DEPTH_W+1:2]),
    .wdata(store_data),
    .rdata(rd_data)
  );

  // Lane extraction and extension of the registered read word.
  always_comb begin
    rd_byte = rd_data[{lane, 3'b000} +: 8];
    rd_half = lane[1] ? rd_data[31:16] : rd_data[15:0];
    unique case (funct3_reg)
      F3_B:    load_data = {{24{rd_byte[7]}}, rd_byte};
      F3_BU:   load_data = {24'h0, rd_byte};
      F3_H:    load_data = {{16{rd_half[15]}}, rd_half};
      F3_HU:   load_data = {16'h0, rd_half};
      default: load_data = rd_data;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    wait_cnt_next   = wait_cnt_reg;
    result_next     = result_reg;
    err_next        = err_reg;
    resp_valid_next = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (req_valid) begin
          wait_cnt_next = 4'd0;
          state_next    = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        if (wait_cnt_reg == WAIT_LAST) begin
          state_next = ACCESS;
        end else begin
          wait_cnt_next = wait_cnt_reg + 4'd1;
        end
      end
      ACCESS: begin
        state_next = RESP;
      end
      RESP: begin
        state_next      = IDLE;
        resp_valid_next = 1'b1;
        err_next        = access_err;
        if (access_err) begin
          result_next = 32'h0;
        end else if (is_load) begin
          result_next = load_data;
        end else begin
          result_next = alu_result_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      wait_cnt_reg   <= 4'd0;
      mem_write_reg  <= 1'b0;
      result_src_reg <= 1'b0;
      funct3_reg     <= 3'b000;
      alu_result_reg <= 32'h0;
      wd_reg         <= 32'h0;
      result_reg     <= 32'h0;
      err_reg        <= 1'b0;
      resp_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wait_cnt_reg   <= wait_cnt_next;
      result_reg     <= result_next;
      err_reg        <= err_next;
      resp_valid_reg <= resp_valid_next;
      if (accept) begin
        mem_write_reg  <= MemWrite;
        result_src_reg <= ResultSrc;
        funct3_reg     <= funct3;
        alu_result_reg <= ALUResult;
        wd_reg         <= WD;
      end
    end
  end

  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = resp_valid_reg;
  assign Result     = result_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder (DEPTH_W=8, WAIT_CYCLES=3).
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DW = 8;
  localparam int WC = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        MemWrite = 1'b0;
  logic        ResultSrc = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] ALUResult = 32'h0;
  logic [31:0] WD = 32'h0;
  logic        resp_valid;
  logic [31:0] Result;
  logic        err;

  dmem_responder #(.DEPTH_W(DW), .WAIT_CYCLES(WC)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .MemWrite  (MemWrite),
    .ResultSrc (ResultSrc),
    .funct3    (funct3),
    .ALUResult (ALUResult),
    .WD        (WD),
    .resp_valid(resp_valid),
    .Result    (Result),
    .err       (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference memory: plain byte array, 4 * 2^DW bytes.
  logic [7:0] mem_m [0:1023];

  typedef struct {
    logic        mw;
    logic        rs;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_r;
    logic        exp_e;
  } vec_t;

  vec_t vt [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Behavioural model: byte-addressed memory with size/alignment rules.
  task automatic model(input logic mw, input logic rs, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] r, output logic e);
    int size;
    int base;
    logic [31:0] v;
    e    = 1'b0;
    r    = a;
    base = int'(a % 1024);
    if (mw || rs) begin
      case (f3)
        3'd0:    size = 1;
        3'd1:    size = 2;
        3'd2:    size = 4;
        3'd4:    size = mw ? 0 : 1;
        3'd5:    size = mw ? 0 : 2;
        default: size = 0;
      endcase
      if (size == 0 || (base % size) != 0) begin
        e = 1'b1;
        r = 32'h0;
      end else if (mw) begin
        for (int k = 0; k < size; k++) mem_m[base + k] = wd[8*k +: 8];
      end else begin
        v = 32'h0;
        for (int k = 0; k < size; k++) v = v | (32'(mem_m[base + k]) << (8 * k));
        if (size == 1 && !f3[2] && v[7]) v = v | 32'hFFFF_FF00;
        if (size == 2 && !f3[2] && v[15]) v = v | 32'hFFFF_0000;
        r = v;
      end
    end
  endtask

  task automatic do_req(input logic mw, input logic rs, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] r, output logic e);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL handshake: req_ready got 0 want 1 (addr %h)", a);
      r = 'x;
      e = 'x;
      return;
    end
    MemWrite  = mw;
    ResultSrc = rs;
    funct3    = f3;
    ALUResult = a;
    WD        = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (resp_valid) break;
      n++;
    end
    if (!resp_valid) begin
      total++;
      bad++;
      $display("FAIL resp_timeout: resp_valid got 0 want 1 (addr %h)", a);
      r = 'x;
      e = 'x;
      return;
    end
    r = Result;
    e = err;
    $display("txn mw=%0d rs=%0d f3=%0d addr=%h wd=%h -> result=%h err=%0d",
             mw, rs, f3, a, wd, r, e);
  endtask

  initial begin
    logic [31:0] r, mr;
    logic        e, me;
    int          cnt;

    vt[0]  = '{1'b1, 1'b0, F3_W,  32'h10,  32'hDEADBEEF, 32'h10,       1'b0};
    vt[1]  = '{1'b0, 1'b1, F3_W,  32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 1'b0, F3_W,  32'h20,  32'h80FF7F01, 32'h20,       1'b0};
    vt[3]  = '{1'b0, 1'b1, F3_B,  32'h21,  32'h0,        32'h0000007F, 1'b0};
    vt[4]  = '{1'b0, 1'b1, F3_B,  32'h23,  32'h0,        32'hFFFFFF80, 1'b0};
    vt[5]  = '{1'b0, 1'b1, F3_BU, 32'h22,  32'h0,        32'h000000FF, 1'b0};
    vt[6]  = '{1'b0, 1'b1, F3_H,  32'h22,  32'h0,        32'hFFFF80FF, 1'b0};
    vt[7]  = '{1'b0, 1'b1, F3_HU, 32'h22,  32'h0,        32'h000080FF, 1'b0};
    vt[8]  = '{1'b1, 1'b0, F3_W,  32'h30,  32'h11223344, 32'h30,       1'b0};
    vt[9]  = '{1'b1, 1'b0, F3_B,  32'h31,  32'h000000AA, 32'h31,       1'b0};
    vt[10] = '{1'b1, 1'b0, F3_H,  32'h32,  32'h0000BEEF, 32'h32,       1'b0};
    vt[11] = '{1'b0, 1'b1, F3_W,  32'h30,  32'h0,        32'hBEEFAA44, 1'b0};
    vt[12] = '{1'b0, 1'b1, F3_W,  32'h41,  32'h0,        32'h0,        1'b1};
    vt[13] = '{1'b1, 1'b0, F3_W,  32'h44,  32'h55667788, 32'h44,       1'b0};
    vt[14] = '{1'b1, 1'b0, F3_W,  32'h46,  32'hCAFEF00D, 32'h0,        1'b1};
    vt[15] = '{1'b0, 1'b1, F3_W,  32'h44,  32'h0,        32'h55667788, 1'b0};
    vt[16] = '{1'b1, 1'b0, F3_W,  32'h400, 32'h0BADF00D, 32'h400,      1'b0};
    vt[17] = '{1'b0, 1'b1, F3_W,  32'h000, 32'h0,        32'h0BADF00D, 1'b0};
    vt[18] = '{1'b0, 1'b0, F3_B,  32'h12345678, 32'h0,   32'h12345678, 1'b0};
    vt[19] = '{1'b1, 1'b0, F3_BU, 32'h48,  32'hFFFFFFFF, 32'h0,        1'b1};
    vt[20] = '{1'b0, 1'b1, F3_W,  32'h48,  32'h0,        32'h0,        1'b0};
    vt[21] = '{1'b0, 1'b1, F3_H,  32'h21,  32'h0,        32'h0,        1'b1};

    // Reset state.
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_result", Result, 32'h0);
    check("rst_err", 32'(err), 32'h0);
    reset = 1'b1;

    // Give the whole array a known value so any load is predictable.
    for (int w = 0; w < 256; w++) do_req(1'b1, 1'b0, F3_W, 32'(w * 4), 32'h0, r, e);
    for (int b = 0; b < 1024; b++) mem_m[b] = 8'h00;

    // Directed table.
    for (int i = 0; i < 22; i++) begin
      do_req(vt[i].mw, vt[i].rs, vt[i].f3, vt[i].addr, vt[i].wd, r, e);
      model(vt[i].mw, vt[i].rs, vt[i].f3, vt[i].addr, vt[i].wd, mr, me);
      check($sformatf("vec%0d_result", i), r, vt[i].exp_r);
      check($sformatf("vec%0d_err", i), 32'(e), 32'(vt[i].exp_e));
    end

    // Latency / handshake: accepted at edge 0, response visible after edge 5.
    @(negedge clk);
    check("lat_ready_before", 32'(req_ready), 32'h1);
    MemWrite  = 1'b0;
    ResultSrc = 1'b0;
    funct3    = F3_W;
    ALUResult = 32'h12345678;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int ed = 0; ed <= 6; ed++) begin
      @(negedge clk);
      check($sformatf("lat_ready_e%0d", ed), 32'(req_ready), 32'(ed >= 5));
      check($sformatf("lat_resp_e%0d", ed), 32'(resp_valid), 32'(ed == 5));
      if (ed == 5) check("lat_result", Result, 32'h12345678);
      if (ed == 1) begin
        ALUResult = 32'hAAAA0000;
        req_valid = 1'b1;
      end
      if (ed == 2) req_valid = 1'b0;
    end
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) cnt++;
    end
    $display("txn latency pass-through -> result=%h", Result);
    check("ignored_pulse_resp_count", 32'(cnt), 32'h0);
    check("result_held", Result, 32'h12345678);

    // Reset during WAIT of a store to 0x50.
    @(negedge clk);
    MemWrite  = 1'b1;
    ResultSrc = 1'b0;
    funct3    = F3_W;
    ALUResult = 32'h50;
    WD        = 32'hFFFFFFFF;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_req_ready", 32'(req_ready), 32'h1);
    check("abort_resp_valid", 32'(resp_valid), 32'h0);
    check("abort_result", Result, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid) cnt++;
    end
    $display("txn aborted store addr=00000050 responses=%0d", cnt);
    check("abort_resp_count", 32'(cnt), 32'h0);
    do_req(1'b0, 1'b1, F3_W, 32'h50, 32'h0, r, e);
    check("abort_load_result", r, 32'h0);
    check("abort_load_err", 32'(e), 32'h0);

    // Randomized traffic against the byte-level model.
    for (int i = 0; i < 150; i++) begin
      logic        mw, rs;
      logic [2:0]  f3;
      logic [31:0] a, wd;
      int          kind;
      kind = int'($urandom_range(0, 9));
      mw   = (kind < 4);
      rs   = mw ? 1'($urandom_range(0, 1)) : (kind < 8);
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = F3_B;
          1: f3 = F3_H;
          2: f3 = F3_W;
          3: f3 = F3_BU;
          default: f3 = F3_HU;
        endcase
      end
      a  = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      wd = $urandom;
      do_req(mw, rs, f3, a, wd, r, e);
      model(mw, rs, f3, a, wd, mr, me);
      check($sformatf("rnd%0d_result", i), r, mr);
      check($sformatf("rnd%0d_err", i), 32'(e), 32'(me));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: sim time got %0t want below limit", $time);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
